sram_access_sequencer: RTL and testbench
========================================

// Module: sram_access_sequencer
// PURPOSE
// - Chassis-side sequencer between the UProc memory port and the external async SRAM pins.
// - Accepts one word access per request and generates setup/strobe/hold timing for CE/OE/WE/UB/LB.
// - Owns the DQ direction (tristate enable) and registers read data.
// - Replaces the direct clock-gated strobe wiring with a counted, contention-free sequence.
// PARAMETERS
// - ADDR_W     16  request address width; zero-extended to the 18-bit SRAM address
// - SETUP_CYC  1   cycles with CE/address (and OE or DQ drive) stable before strobe; 0 treated as 1
// - STROBE_CYC 2   cycles UB/LB (and WE for writes) held low; 0 treated as 1
// - HOLD_CYC   1   cycles after strobe release before bus release; 0 treated as 1
// PORTS
// - i_sysClk      in   1       single system clock, all logic rising-edge
// - i_sysRst      in   1       synchronous reset, active-high
// - i_req         in   1       access request, sampled only in IDLE
// - i_wr          in   1       1 = write, 0 = read; captured with i_req
// - i_addr        in   ADDR_W  word address; captured with i_req
// - i_wrData      in   16      write data; captured with i_req
// - o_busy        out  1       high from cycle after acceptance until return to IDLE
// - o_ack         out  1       one-cycle completion pulse
// - o_rdData      out  16      last read word; held until next read completes
// - o_sramAddr    out  18      {zero pad, captured address}
// - o_sramCeN     out  1       chip enable, active-low
// - o_sramOeN     out  1       output enable, active-low
// - o_sramWeN     out  1       write enable, active-low
// - o_sramUbN     out  1       upper byte enable, active-low
// - o_sramLbN     out  1       lower byte enable, active-low
// - o_sramDqOut   out  16      data driven onto DQ when o_sramDqOe = 1
// - o_sramDqOe    out  1       DQ drive enable; top level tristates DQ when 0
// - i_sramDq      in   16      DQ pin value, sampled for reads
// BEHAVIOUR
// - Reset: state IDLE. All *N outputs = 1; o_sramDqOe = 0; o_busy = 0; o_ack = 0.
//   o_rdData, o_sramAddr and o_sramDqOut = 0. Counter = 0.
// - All outputs are registered. FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
// - IDLE: when i_req = 1, capture i_wr/i_addr/i_wrData and go to SETUP; otherwise stay.
// - SETUP (SETUP_CYC cycles):
//   - CeN = 0; address driven.
//   - Read: OeN = 0, DqOe = 0.
//   - Write: OeN = 1, DqOe = 1, DqOut = captured data.
// - STROBE (STROBE_CYC cycles): UbN = LbN = 0; write also drives WeN = 0.
// - Read data: i_sramDq is registered into o_rdData on the last STROBE cycle.
// - HOLD (HOLD_CYC cycles): WeN = UbN = LbN = 1; CeN stays 0.
//   Write keeps DqOe = 1; read keeps OeN = 0.
// - Exit HOLD -> IDLE: CeN = OeN = 1, DqOe = 0. o_ack = 1 for exactly that first IDLE cycle.
// - Latency: request cycle to ack cycle = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 (default 5).
// - Back-to-back: i_req high in the ack cycle is accepted; CE may stay deasserted only that one cycle.
// - i_req while busy: ignored and not queued; the requester must hold i_req until accepted.
// - Invariants, every cycle:
//   - never WeN = 0 and OeN = 0 together;
//   - never DqOe = 1 while OeN = 0;
//   - WeN/UbN/LbN = 0 only in STROBE.
// - Counter: width $clog2(max cycle param) + 1. Reloads on each state entry; state advances when count hits param-1.
// - Reset mid-operation: next edge forces the reset values. No ack; the in-flight access is dropped.
// TESTING
// - Reset asserted mid-STROBE of a write -> next cycle WeN = UbN = LbN = CeN = 1, DqOe = 0, o_ack never pulses.
// - Write addr 0x1234 data 0xBEEF (defaults):
//   - o_sramAddr = 0x01234; DqOe = 1 for 4 cycles;
//   - WeN low for exactly 2 cycles;
//   - o_ack in cycle 5 after request.
// - Read addr 0x00FF, model returns 0xA5C3:
//   - OeN low 4 cycles, WeN stays 1, DqOe stays 0;
//   - o_rdData = 0xA5C3 at ack and held through a following write.
// - i_req held high continuously, write then read:
//   - second access accepted in the first ack cycle;
//   - acks exactly 5 cycles apart; invariants hold.
// - i_req pulsed while busy -> no extra access and no extra ack.
// - SETUP_CYC = 0, STROBE_CYC = 3, HOLD_CYC = 2 -> setup runs 1 cycle, strobe 3, hold 2; ack 7 cycles after request.

Source files
------------

// File: rtl/sram_access_sequencer.sv
// Single-word async SRAM access sequencer: counted setup/strobe/hold phases with
// registered strobes, DQ direction control and registered read data.
module sram_access_sequencer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              i_sysClk,
  input  logic              i_sysRst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wrData,
  output logic              o_busy,
  output logic              o_ack,
  output logic [15:0]       o_rdData,
  output logic [17:0]       o_sramAddr,
  output logic              o_sramCeN,
  output logic              o_sramOeN,
  output logic              o_sramWeN,
  output logic              o_sramUbN,
  output logic              o_sramLbN,
  output logic [15:0]       o_sramDqOut,
  output logic              o_sramDqOe,
  input  logic [15:0]       i_sramDq
);

  localparam int unsigned SetupLen  = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned StrobeLen = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
  localparam int unsigned HoldLen   = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
  localparam int unsigned MaxLen    = (SetupLen > StrobeLen) ?
                                      ((SetupLen > HoldLen) ? SetupLen : HoldLen) :
                                      ((StrobeLen > HoldLen) ? StrobeLen : HoldLen);
  localparam int unsigned CntW      = $clog2(MaxLen) + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [17:0]     sram_addr_q, sram_addr_d;
  logic [15:0]     dq_out_q, dq_out_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            bs_n_q, bs_n_d;
  logic            dq_oe_q, dq_oe_d;

  always_ff @(posedge i_sysClk) begin
    if (i_sysRst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      rd_data_q   <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bs_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bs_n_q      <= bs_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    wr_d        = wr_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    rd_data_d   = rd_data_q;
    ack_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_req) begin
          state_d     = StSetup;
          wr_d        = i_wr;
          sram_addr_d = 18'(i_addr);
          dq_out_d    = i_wrData;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SetupLen - 1)) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end
      end
      StStrobe: begin
        if (cnt_q == CntW'(StrobeLen - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
          if (!wr_q) rd_data_d = i_sramDq;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(HoldLen - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Pin levels are decoded from the next state so every output is a flop.
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    bs_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    busy_d  = (state_d != StIdle);
    if (state_d != StIdle) begin
      ce_n_d  = 1'b0;
      oe_n_d  = wr_d;
      dq_oe_d = wr_d;
    end
    if (state_d == StStrobe) begin
      bs_n_d = 1'b0;
      we_n_d = ~wr_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_ack       = ack_q;
  assign o_rdData    = rd_data_q;
  assign o_sramAddr  = sram_addr_q;
  assign o_sramCeN   = ce_n_q;
  assign o_sramOeN   = oe_n_q;
  assign o_sramWeN   = we_n_q;
  assign o_sramUbN   = bs_n_q;
  assign o_sramLbN   = bs_n_q;
  assign o_sramDqOut = dq_out_q;
  assign o_sramDqOe  = dq_oe_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: ack/read-data scoreboard, per-cycle bus checks,
// and a second instance with non-default phase lengths.
module tb_sram_access_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, wr;
  logic [15:0] addr, wdata;
  logic        busy, ack, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
  logic [15:0] rd, dq_out, dq_in;
  logic [17:0] saddr;

  logic        b_req, b_wr;
  logic [15:0] b_addr, b_wdata;
  logic        b_busy, b_ack, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n, b_dq_oe;
  logic [15:0] b_rd, b_dq_out, b_dq_in;
  logic [17:0] b_saddr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    bit          chk_rd;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  // SRAM read model: fixed word at 0xFF, otherwise derived from the address.
  function automatic logic [15:0] sram_model(input logic [17:0] a);
    return (a == 18'h000FF) ? 16'hA5C3 : {a[7:0], ~a[7:0]};
  endfunction

  assign dq_in   = !oe_n ? sram_model(saddr) : 16'h0000;
  assign b_dq_in = !b_oe_n ? sram_model(b_saddr) : 16'h0000;

  sram_access_sequencer dut (
    .i_sysClk(clk), .i_sysRst(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
    .i_wrData(wdata), .o_busy(busy), .o_ack(ack), .o_rdData(rd), .o_sramAddr(saddr),
    .o_sramCeN(ce_n), .o_sramOeN(oe_n), .o_sramWeN(we_n), .o_sramUbN(ub_n),
    .o_sramLbN(lb_n), .o_sramDqOut(dq_out), .o_sramDqOe(dq_oe), .i_sramDq(dq_in)
  );

  sram_access_sequencer #(.ADDR_W(16), .SETUP_CYC(0), .STROBE_CYC(3), .HOLD_CYC(2)) dut2 (
    .i_sysClk(clk), .i_sysRst(rst), .i_req(b_req), .i_wr(b_wr), .i_addr(b_addr),
    .i_wrData(b_wdata), .o_busy(b_busy), .o_ack(b_ack), .o_rdData(b_rd),
    .o_sramAddr(b_saddr), .o_sramCeN(b_ce_n), .o_sramOeN(b_oe_n), .o_sramWeN(b_we_n),
    .o_sramUbN(b_ub_n), .o_sramLbN(b_lb_n), .o_sramDqOut(b_dq_out), .o_sramDqOe(b_dq_oe),
    .i_sramDq(b_dq_in)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Bus invariants and the ack scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en) begin
      checks++;
      if ((!we_n && !oe_n) || (!b_we_n && !b_oe_n)) begin
        errors++;
        $display("FAIL inv_we_oe cyc=%0d we_n=%b oe_n=%b b_we_n=%b b_oe_n=%b",
                 cyc, we_n, oe_n, b_we_n, b_oe_n);
      end
      checks++;
      if ((dq_oe && !oe_n) || (b_dq_oe && !b_oe_n)) begin
        errors++;
        $display("FAIL inv_dqoe_oe cyc=%0d dq_oe=%b oe_n=%b", cyc, dq_oe, oe_n);
      end
      checks++;
      if ((!we_n && ub_n) || (ub_n !== lb_n)) begin
        errors++;
        $display("FAIL inv_strobe cyc=%0d we_n=%b ub_n=%b lb_n=%b", cyc, we_n, ub_n, lb_n);
      end
      if (ack) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack cyc=%0d got ack want none", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL ack_cycle got=%0d want=%0d", cyc, e.cyc);
          end
          if (e.chk_rd && rd !== e.rd) begin
            errors++;
            $display("FAIL ack_rdata got=%h want=%h", rd, e.rd);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, busy, ack} !== 8'b11111000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=11111000",
               {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, busy, ack});
    end
    checks++;
    if (rd !== 16'h0 || saddr !== 18'h0 || dq_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got rd=%h addr=%h dq=%h want 0", rd, saddr, dq_out);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_write();
    int c, we_cnt, dq_cnt, oe_cnt, ack_at;
    we_cnt = 0; dq_cnt = 0; oe_cnt = 0; ack_at = -1;
    @(negedge clk);
    c = cyc;
    req = 1'b1; wr = 1'b1; addr = 16'h1234; wdata = 16'hBEEF;
    sb.push_back('{cyc: c + 5, chk_rd: 1'b0, rd: 16'h0});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (!we_n) we_cnt++;
      if (dq_oe) dq_cnt++;
      if (!oe_n) oe_cnt++;
      if (ack) ack_at = i;
      if (i == 1) begin
        checks++;
        if (saddr !== 18'h01234) begin
          errors++;
          $display("FAIL wr_addr got=%h want=01234", saddr);
        end
      end
      if (i == 2) begin
        checks++;
        if (dq_out !== 16'hBEEF) begin
          errors++;
          $display("FAIL wr_dq got=%h want=beef", dq_out);
        end
      end
    end
    checks++;
    if (we_cnt !== 2) begin errors++; $display("FAIL wr_we_low got=%0d want=2", we_cnt); end
    checks++;
    if (dq_cnt !== 4) begin errors++; $display("FAIL wr_dqoe got=%0d want=4", dq_cnt); end
    checks++;
    if (oe_cnt !== 0) begin errors++; $display("FAIL wr_oe_low got=%0d want=0", oe_cnt); end
    checks++;
    if (ack_at !== 5) begin errors++; $display("FAIL wr_ack_at got=%0d want=5", ack_at); end
  endtask

  task automatic test_read();
    int c, we_cnt, dq_cnt, oe_cnt;
    we_cnt = 0; dq_cnt = 0; oe_cnt = 0;
    @(negedge clk);
    c = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h00FF;
    sb.push_back('{cyc: c + 5, chk_rd: 1'b1, rd: 16'hA5C3});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (!we_n) we_cnt++;
      if (dq_oe) dq_cnt++;
      if (!oe_n) oe_cnt++;
    end
    checks++;
    if (oe_cnt !== 4) begin errors++; $display("FAIL rd_oe_low got=%0d want=4", oe_cnt); end
    checks++;
    if (we_cnt !== 0 || dq_cnt !== 0) begin
      errors++;
      $display("FAIL rd_we_dq got we=%0d dq=%0d want 0 0", we_cnt, dq_cnt);
    end
    // A following write must leave the read word untouched.
    @(negedge clk);
    c = cyc;
    req = 1'b1; wr = 1'b1; addr = 16'h0005; wdata = 16'h5A5A;
    sb.push_back('{cyc: c + 5, chk_rd: 1'b0, rd: 16'h0});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    checks++;
    if (rd !== 16'hA5C3) begin errors++; $display("FAIL rd_held got=%h want=a5c3", rd); end
  endtask

  task automatic test_back_to_back();
    int c, n_ack, a1, a2;
    n_ack = 0; a1 = -1; a2 = -1;
    @(negedge clk);
    c = cyc;
    req = 1'b1; wr = 1'b1; addr = 16'h0042; wdata = 16'h1111;
    sb.push_back('{cyc: c + 5, chk_rd: 1'b0, rd: 16'h0});
    sb.push_back('{cyc: c + 10, chk_rd: 1'b1, rd: 16'h7788});
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (ack) begin
        n_ack++;
        if (n_ack == 1) a1 = cyc; else a2 = cyc;
      end
      if (i == 5) begin
        checks++;
        if (ce_n !== 1'b1) begin errors++; $display("FAIL b2b_ce_gap got=%b want=1", ce_n); end
      end
      if (i == 6) begin
        checks++;
        if (ce_n !== 1'b0) begin errors++; $display("FAIL b2b_ce_next got=%b want=0", ce_n); end
        req = 1'b0;
      end
      if (i == 1) begin
        wr = 1'b0; addr = 16'h0077;
      end
    end
    checks++;
    if (n_ack !== 2 || (a2 - a1) !== 5) begin
      errors++;
      $display("FAIL b2b_acks got n=%0d gap=%0d want n=2 gap=5", n_ack, a2 - a1);
    end
  endtask

  task automatic test_busy_pulse();
    int c, n_ack, ce_cnt;
    n_ack = 0; ce_cnt = 0;
    @(negedge clk);
    c = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h0010;
    sb.push_back('{cyc: c + 5, chk_rd: 1'b1, rd: 16'h10EF});
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (!ce_n) ce_cnt++;
      req = (i == 2 || i == 3);
    end
    checks++;
    if (n_ack !== 1) begin errors++; $display("FAIL busy_acks got=%0d want=1", n_ack); end
    checks++;
    if (ce_cnt !== 4) begin errors++; $display("FAIL busy_ce_low got=%0d want=4", ce_cnt); end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    n_ack = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h0300; wdata = 16'hCAFE;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (we_n !== 1'b0) begin errors++; $display("FAIL mid_in_strobe got we_n=%b want=0", we_n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({we_n, ub_n, lb_n, ce_n, oe_n, dq_oe, busy, ack} !== 8'b11111000) begin
      errors++;
      $display("FAIL mid_reset got=%b want=11111000",
               {we_n, ub_n, lb_n, ce_n, oe_n, dq_oe, busy, ack});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    checks++;
    if (n_ack !== 0) begin errors++; $display("FAIL mid_no_ack got=%0d want=0", n_ack); end
  endtask

  task automatic test_params();
    int c, ce_cnt, st_cnt, setup_cnt, hold_cnt, ack_at;
    bit seen_st;
    logic [15:0] rd_at_ack;
    ce_cnt = 0; st_cnt = 0; setup_cnt = 0; hold_cnt = 0; ack_at = -1; seen_st = 1'b0;
    rd_at_ack = 16'h0;
    @(negedge clk);
    c = cyc;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0020;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      b_req = 1'b0;
      if (!b_ce_n) ce_cnt++;
      if (!b_ub_n) begin st_cnt++; seen_st = 1'b1; end
      else if (!b_ce_n && !seen_st) setup_cnt++;
      else if (!b_ce_n) hold_cnt++;
      if (b_ack) begin ack_at = cyc - c; rd_at_ack = b_rd; end
    end
    checks++;
    if (setup_cnt !== 1 || st_cnt !== 3 || hold_cnt !== 2) begin
      errors++;
      $display("FAIL par_phases got=%0d/%0d/%0d want=1/3/2", setup_cnt, st_cnt, hold_cnt);
    end
    checks++;
    if (ce_cnt !== 6) begin errors++; $display("FAIL par_ce_low got=%0d want=6", ce_cnt); end
    checks++;
    if (ack_at !== 7) begin errors++; $display("FAIL par_ack_lat got=%0d want=7", ack_at); end
    checks++;
    if (rd_at_ack !== 16'h20DF) begin
      errors++;
      $display("FAIL par_rdata got=%h want=20df", rd_at_ack);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_pulse();
    test_reset_mid();
    test_params();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=no_finish want=finish");
    $fatal(1, "timeout");
  end

endmodule
